// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_pkg
//  Purpose  : Shared types and constants for the Sobel window generator.
//  Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pix_t;
    typedef pix_t [8:0]           window_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } win_state_e;

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_line_buffer
//  Purpose  : One image line of storage. Combinational read of the addressed
//             entry, synchronous write, so a read and a write to the same
//             address in one cycle return the old contents.
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign rdata = r_mem[addr];

    // Contents need no reset; they are always overwritten before being used.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_window_gen
//  Purpose  : Builds the 3x3 pixel neighbourhood from a raster pixel stream
//             and strobes start_calculations for every interior pixel.
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic [PIX_W-1:0] P0,
    output logic [PIX_W-1:0] P1,
    output logic [PIX_W-1:0] P2,
    output logic [PIX_W-1:0] P3,
    output logic [PIX_W-1:0] P4,
    output logic [PIX_W-1:0] P5,
    output logic [PIX_W-1:0] P6,
    output logic [PIX_W-1:0] P7,
    output logic [PIX_W-1:0] P8,
    output logic             start_calculations,
    input  logic             win_ready,
    output logic             frame_done
);

    localparam int c_col_w = $clog2(IMG_WIDTH);
    localparam int c_row_w = $clog2(IMG_HEIGHT);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);

    win_state_e         r_state;
    win_state_e         w_state_nxt;
    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic [PIX_W-1:0]   r_win [9];
    logic               r_sc;
    logic [PIX_W-1:0]   w_lb0_rd;
    logic [PIX_W-1:0]   w_lb1_rd;

    // A pending, unacknowledged window stalls the input; reset also blocks it.
    assign pix_ready = !rst && !(r_sc && !win_ready);

    logic w_accept;
    logic w_proc;
    logic [c_col_w-1:0] w_col;
    logic [c_row_w-1:0] w_row;
    logic w_col_last;
    logic w_row_last;
    logic w_qual;

    assign w_accept   = pix_valid && pix_ready;
    // Outside a frame only a start-of-frame pixel is used; others are dropped.
    assign w_proc     = w_accept && (pix_sof || r_state == FILL || r_state == RUN);
    // A start-of-frame pixel always lands at (0,0), even mid-frame.
    assign w_col      = pix_sof ? '0 : r_col;
    assign w_row      = pix_sof ? '0 : r_row;
    assign w_col_last = (w_col == c_col_last);
    assign w_row_last = (w_row == c_row_last);
    assign w_qual     = w_proc && (w_row >= c_row_w'(2)) && (w_col >= c_col_w'(2));

    // lb1 holds the previous line, lb0 the line before it; the old lb1 entry
    // migrates to lb0 as the new pixel replaces it.
    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (w_proc),
        .addr  (w_col),
        .wdata (w_lb1_rd),
        .rdata (w_lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (w_proc),
        .addr  (w_col),
        .wdata (pix_in),
        .rdata (w_lb1_rd)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame sequencing and the end-of-frame pulse.
    always_comb begin
        w_state_nxt = r_state;
        frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && pix_sof) w_state_nxt = FILL;
            end
            FILL: begin
                if (w_accept && pix_sof) begin
                    w_state_nxt = FILL;
                end else if (w_proc && w_col_last && (w_row == c_row_w'(1))) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_accept && pix_sof) begin
                    w_state_nxt = FILL;
                end else if (w_proc && w_col_last && w_row_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = (w_accept && pix_sof) ? FILL : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Position counters, window shift register and the window-valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_sc  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            if (w_proc) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : w_row + c_row_w'(1);
                end else begin
                    r_col <= w_col + c_col_w'(1);
                    r_row <= w_row;
                end
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb0_rd;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb1_rd;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pix_in;
            end
            if (w_qual) begin
                r_sc <= 1'b1;
            end else if (win_ready) begin
                r_sc <= 1'b0;
            end
        end
    end

    assign start_calculations = r_sc;
    assign P0 = r_win[0];
    assign P1 = r_win[1];
    assign P2 = r_win[2];
    assign P3 = r_win[3];
    assign P4 = r_win[4];
    assign P5 = r_win[5];
    assign P6 = r_win[6];
    assign P7 = r_win[7];
    assign P8 = r_win[8];

endmodule
`default_nettype wire
